// File: rtl/xsha_round_ctrl.sv
// xsha_round_ctrl: SHA-256 round sequencer; streams K[t]/W[t] to the round unit, holds H0..H7, feed-forward in FINAL.
// Latency run->done = delay0+66 cycles; no backpressure, run restarts the block from any state.
// Optional in-block message expansion enabled by defining XSHA_CTRL_W_SCHED_EN.
module xsha_round_ctrl #(
   parameter int DELAY_W = 8,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   output logic               done,
   input  logic [DATA_W-1:0]  in0,
   input  logic [DATA_W-1:0]  in1,
   input  logic [DATA_W-1:0]  in2,
   input  logic [DATA_W-1:0]  in3,
   input  logic [DATA_W-1:0]  in4,
   input  logic [DATA_W-1:0]  in5,
   input  logic [DATA_W-1:0]  in6,
   input  logic [DATA_W-1:0]  in7,
   input  logic [DATA_W-1:0]  in8,
   output logic [DATA_W-1:0]  out0,
   output logic [DATA_W-1:0]  out1,
   output logic [DATA_W-1:0]  out2,
   output logic [DATA_W-1:0]  out3,
   output logic [DATA_W-1:0]  out4,
   output logic [DATA_W-1:0]  out5,
   output logic [DATA_W-1:0]  out6,
   output logic [DATA_W-1:0]  out7,
   output logic [DATA_W-1:0]  out8,
   output logic [DATA_W-1:0]  out9,
   input  logic [DELAY_W-1:0] delay0,
   input  logic               init
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ROUND, ST_FINAL} state_t;

   localparam logic [DATA_W-1:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [DATA_W-1:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   state_t              state_q, state_d;
   logic [DELAY_W-1:0]  dly_q, dly_d;
   logic [5:0]          t_q, t_d;
   logic [DATA_W-1:0]   h_q [8];
   logic [DATA_W-1:0]   h_d [8];
   logic [DATA_W-1:0]   w_hold_q, w_hold_d;
   logic [DATA_W-1:0]   k_hold_q, k_hold_d;
   logic [DATA_W-1:0]   unit_st [8];
   logic [DATA_W-1:0]   w_cur;
   logic [DATA_W-1:0]   k_cur;
   logic                rnd_act;

   assign unit_st = '{in0, in1, in2, in3, in4, in5, in6, in7};

   // The last WAIT cycle (dly==0) is round 0, so the unit sees W[0]/K[0] there.
   assign rnd_act = ((state_q == ST_WAIT) && (dly_q == '0)) || (state_q == ST_ROUND);
   assign k_cur   = K_ROM[t_q];

`ifdef XSHA_CTRL_W_SCHED_EN
   // win_q[15] is W[t-1], win_q[0] is W[t-16].
   logic [DATA_W-1:0] win_q [16];
   logic [DATA_W-1:0] win_d [16];

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   assign w_cur = (t_q < 6'd16) ? in8
                : sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

   always_comb begin
      win_d = win_q;
      if (rnd_act) begin
         for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
         win_d[15] = w_cur;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else begin
         win_q <= win_d;
      end
   end
`else
   assign w_cur = in8;
`endif

   assign out8 = rnd_act ? w_cur : w_hold_q;
   assign out9 = rnd_act ? k_cur : k_hold_q;
   assign done = (state_q == ST_IDLE);

   assign out0 = h_q[0];
   assign out1 = h_q[1];
   assign out2 = h_q[2];
   assign out3 = h_q[3];
   assign out4 = h_q[4];
   assign out5 = h_q[5];
   assign out6 = h_q[6];
   assign out7 = h_q[7];

   always_comb begin
      state_d  = state_q;
      dly_d    = dly_q;
      t_d      = t_q;
      h_d      = h_q;
      w_hold_d = rnd_act ? w_cur : w_hold_q;
      k_hold_d = rnd_act ? k_cur : k_hold_q;
      if (run) begin
         state_d = ST_WAIT;
         dly_d   = delay0;
         t_d     = '0;
         if (init) h_d = IV;
      end else begin
         case (state_q)
            ST_WAIT: begin
               if (dly_q == '0) begin
                  state_d = ST_ROUND;
                  t_d     = t_q + 6'd1;
               end else begin
                  dly_d = dly_q - 1'b1;
               end
            end
            ST_ROUND: begin
               if (t_q == 6'd63) state_d = ST_FINAL;
               else              t_d     = t_q + 6'd1;
            end
            ST_FINAL: begin
               // H stays frozen until here: the unit only latches it at round 0.
               for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + unit_st[i];
               state_d = ST_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         dly_q    <= '0;
         t_q      <= '0;
         w_hold_q <= '0;
         k_hold_q <= '0;
         for (int i = 0; i < 8; i++) h_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         dly_q    <= dly_d;
         t_q      <= t_d;
         w_hold_q <= w_hold_d;
         k_hold_q <= k_hold_d;
         h_q      <= h_d;
      end
   end

endmodule

// File: tb/tb_xsha_round_ctrl.sv
// Bench for xsha_round_ctrl: emulates the SHA-256 round unit around the controller and
// scoreboards digests, run->done latency and the per-round W/K stream.
module tb_xsha_round_ctrl;

   typedef logic [0:7][31:0]  st_t;
   typedef logic [0:15][31:0] blk_t;
   typedef struct {
      st_t h;
      bit  chk_h;
      int  lat;
   } exp_t;

   localparam st_t DIG_ABC = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   localparam st_t DIG_TWO = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                               32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
   localparam blk_t BLK_ABC = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
   localparam blk_t BLK_M1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam blk_t BLK_M2 = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};

   logic        clk = 1'b0;
   logic        rst, run, init, done;
   logic [7:0]  delay0;
   logic [31:0] in8;
   logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7, out8, out9;
   st_t         h_now;

   // Round-unit emulation state
   st_t         ust;
   logic        m_act;
   logic [7:0]  m_cnt;
   logic [5:0]  m_r;
   logic [31:0] wexp [64];

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   run_edge = 0;
   bit   prev_done = 1'b1;

   xsha_round_ctrl dut (
      .clk(clk), .rst(rst), .run(run), .done(done),
      .in0(ust[0]), .in1(ust[1]), .in2(ust[2]), .in3(ust[3]),
      .in4(ust[4]), .in5(ust[5]), .in6(ust[6]), .in7(ust[7]), .in8(in8),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
      .out5(out5), .out6(out6), .out7(out7), .out8(out8), .out9(out9),
      .delay0(delay0), .init(init)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign h_now = {out0, out1, out2, out3, out4, out5, out6, out7};
   assign in8   = (m_act && m_cnt == 8'd0) ? wexp[m_r] : 32'h0;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic st_t sha_round(input st_t s, input logic [31:0] w, input logic [31:0] k);
      logic [31:0] t1, t2;
      t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
      t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
   endfunction

   // Round unit: shares run/delay0, latches H at round 0, one round per cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act <= 1'b0;
         m_cnt <= 8'd0;
         m_r   <= 6'd0;
         ust   <= '0;
      end else if (run) begin
         m_act <= 1'b1;
         m_cnt <= delay0;
         m_r   <= 6'd0;
      end else if (m_act) begin
         if (m_cnt != 8'd0) begin
            m_cnt <= m_cnt - 8'd1;
         end else begin
            ust <= sha_round((m_r == 6'd0) ? h_now : ust, out8, out9);
            if (m_r == 6'd63) m_act <= 1'b0;
            else              m_r   <= m_r + 6'd1;
         end
      end
   end

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: per-round stream checks and scoreboard pop on each done rise.
   always @(negedge clk) begin
      if (rst) begin
         prev_done = done;
      end else begin
         if (m_act && m_cnt == 8'd0) begin
            chk32($sformatf("w_t%0d", m_r), out8, wexp[m_r]);
            if (m_r == 6'd0) chk32("k_t0", out9, 32'h428a2f98);
         end
         if (done && !prev_done) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL early_done: done rose at cycle %0d with no block expected", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk_int("latency", cyc - run_edge + 1, e.lat);
               if (e.chk_h)
                  for (int i = 0; i < 8; i++) chk32($sformatf("H%0d", i), h_now[i], e.h[i]);
            end
         end
         prev_done = done;
      end
   end

   task automatic load_block(input blk_t m);
      logic [31:0] a, b;
      for (int t = 0; t < 16; t++) wexp[t] = m[t];
      for (int t = 16; t < 64; t++) begin
         a = rotr(wexp[t-15], 7) ^ rotr(wexp[t-15], 18) ^ (wexp[t-15] >> 3);
         b = rotr(wexp[t-2], 17) ^ rotr(wexp[t-2], 19) ^ (wexp[t-2] >> 10);
         wexp[t] = b + wexp[t-7] + a + wexp[t-16];
      end
   endtask

   task automatic push_exp(input st_t h, input bit chk_h, input int lat);
      exp_t e;
      e.h = h;
      e.chk_h = chk_h;
      e.lat = lat;
      sb.push_back(e);
   endtask

   // Called and returns at posedge+2; cycle 0 is the cycle in which run is sampled.
   task automatic drive_run(input bit i, input logic [7:0] d);
      init = i;
      delay0 = d;
      run = 1'b1;
      run_edge = cyc + 1;
      @(posedge clk); #2;
      run = 1'b0;
   endtask

   task automatic wait_sb(input int limit);
      for (int i = 0; i < limit && sb.size() != 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: %0d block(s) outstanding after %0d cycles", sb.size(), limit);
         sb.delete();
      end
      @(posedge clk); #2;
   endtask

   task automatic wait_round(input int r);
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(posedge clk); #2;
         if (m_act && m_cnt == 8'd0 && m_r == 6'(r)) hit = 1'b1;
      end
      n_vec++;
      if (!hit) begin
         n_err++;
         $display("FAIL round_timeout: round %0d never reached", r);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk32({tag, "_done"}, {31'b0, done}, 32'h1);
      for (int i = 0; i < 8; i++) chk32($sformatf("%s_H%0d", tag, i), h_now[i], 32'h0);
      chk32({tag, "_out8"}, out8, 32'h0);
      chk32({tag, "_out9"}, out9, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      run = 1'b0;
      init = 1'b0;
      delay0 = 8'd0;
      for (int t = 0; t < 64; t++) wexp[t] = 32'h0;
      repeat (3) @(posedge clk);
      #2;
      chk_reset("rst0");
      rst = 1'b0;
      @(posedge clk); #2;

      // "abc", init=1, delay0=0
      load_block(BLK_ABC);
      push_exp(DIG_ABC, 1'b1, 66);
      drive_run(1'b1, 8'd0);
      wait_sb(200);

      // same block, delay0=5
      push_exp(DIG_ABC, 1'b1, 71);
      drive_run(1'b1, 8'd5);
      wait_sb(200);

      // two-block message chained with init=0 on the second block
      load_block(BLK_M1);
      push_exp(DIG_TWO, 1'b0, 66);
      drive_run(1'b1, 8'd0);
      wait_sb(200);
      load_block(BLK_M2);
      push_exp(DIG_TWO, 1'b1, 66);
      drive_run(1'b0, 8'd0);
      wait_sb(200);

      // abort at t=30 and restart; no done may appear for the aborted block
      load_block(BLK_ABC);
      drive_run(1'b1, 8'd0);
      wait_round(30);
      push_exp(DIG_ABC, 1'b1, 66);
      drive_run(1'b1, 8'd0);
      wait_sb(200);

      // reset mid-block at t=40, then a clean block
      drive_run(1'b1, 8'd0);
      wait_round(40);
      rst = 1'b1;
      @(posedge clk); #2;
      chk_reset("rst40");
      rst = 1'b0;
      @(posedge clk); #2;
      push_exp(DIG_ABC, 1'b1, 66);
      drive_run(1'b1, 8'd0);
      wait_sb(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      n_err++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
